// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter of the multicycle MIPS core.
package mips_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  localparam int STATS_W = 16;
  // Wide enough for the largest legal MEM_LAT-1 wait count.
  localparam int CNT_W   = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// One requester channel into the memory arbiter (CPU datapath or debug loader).
interface mem_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  // req/ack handshake: the master raises req with we/addr/wdata stable and holds
  // all of them until ack; ack is a single-cycle pulse, rdata is valid with ack
  // for reads and holds until the next read completes. A req still high in the
  // cycle after ack starts a new access.
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating event counter with asynchronous active-high clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the fixed-latency unified MIPS memory between CPU and debug loader.
// Optional grant/stall statistics outputs are built when ARB_STATS_EN is defined.
module mem_arbiter
  import mips_arb_pkg::*;
#(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      cpu,
  mem_arbiter_if.slave      dbg,
  input  logic              dbg_lock,
  output logic              cpu_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output arb_state_t        o_state
`ifdef ARB_STATS_EN
  ,
  output logic [STATS_W-1:0] cpu_grants,
  output logic [STATS_W-1:0] dbg_grants,
  output logic [STATS_W-1:0] stall_cycles
`endif
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

  arb_state_t        r_state;
  owner_t            r_owner;
  owner_t            r_last_grant;
  logic              r_we;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_cpu_ack;
  logic              r_dbg_ack;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;

  logic   w_cpu_elig;
  logic   w_dbg_elig;
  logic   w_any_elig;
  owner_t w_grant;

  assign w_cpu_elig = cpu.req & ~dbg_lock;
  assign w_dbg_elig = dbg.req;
  assign w_any_elig = w_cpu_elig | w_dbg_elig;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    w_grant = OWN_DBG;
    if (w_cpu_elig && (!w_dbg_elig || (r_last_grant == OWN_DBG))) begin
      w_grant = OWN_CPU;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_owner      <= OWN_CPU;
      r_last_grant <= OWN_DBG;
      r_we         <= 1'b0;
      r_cnt        <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_ack    <= 1'b0;
      r_dbg_ack    <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dbg_rdata  <= '0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_dbg_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_elig) begin
            r_state      <= ISSUE;
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
            r_mem_en     <= 1'b1;
            if (w_grant == OWN_CPU) begin
              r_we        <= cpu.we;
              r_mem_we    <= cpu.we;
              r_mem_addr  <= cpu.addr;
              r_mem_wdata <= cpu.wdata;
            end else begin
              r_we        <= dbg.we;
              r_mem_we    <= dbg.we;
              r_mem_addr  <= dbg.addr;
              r_mem_wdata <= dbg.wdata;
            end
          end
        end
        ISSUE: begin
          r_state     <= WAIT;
          r_cnt       <= LAT_M1;
          r_mem_en    <= 1'b0;
          r_mem_we    <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ACK;
            if (r_owner == OWN_CPU) begin
              r_cpu_ack <= 1'b1;
              if (!r_we) r_cpu_rdata <= mem_rdata;
            end else begin
              r_dbg_ack <= 1'b1;
              if (!r_we) r_dbg_rdata <= mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ACK: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu.ack   = r_cpu_ack;
  assign cpu.rdata = r_cpu_rdata;
  assign dbg.ack   = r_dbg_ack;
  assign dbg.rdata = r_dbg_rdata;
  assign cpu_stall = cpu.req & ~r_cpu_ack;
  assign busy      = (r_state != IDLE);
  assign o_state   = r_state;

`ifdef ARB_STATS_EN
  logic w_grant_fire;
  assign w_grant_fire = (r_state == IDLE) && w_any_elig;

  sat_counter #(.W(STATS_W)) u_cpu_grants (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_grant_fire && (w_grant == OWN_CPU)),
    .count (cpu_grants)
  );

  sat_counter #(.W(STATS_W)) u_dbg_grants (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_grant_fire && (w_grant == OWN_DBG)),
    .count (dbg_grants)
  );

  sat_counter #(.W(STATS_W)) u_stall_cycles (
    .clk   (clk),
    .rst   (rst),
    .inc   (cpu_stall),
    .count (stall_cycles)
  );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency RAM model behind the memory port.
module tb_mem_arbiter;
  import mips_arb_pkg::*;

  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              dbg_lock = 1'b0;
  logic              cpu_stall, mem_en, mem_we, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  arb_state_t        o_state;
`ifdef ARB_STATS_EN
  logic [15:0] cpu_grants, dbg_grants, stall_cycles;
`endif

  int checks = 0;
  int failures = 0;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_if ();
  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dbg_if ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu       (cpu_if),
    .dbg       (dbg_if),
    .dbg_lock  (dbg_lock),
    .cpu_stall (cpu_stall),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .o_state   (o_state)
`ifdef ARB_STATS_EN
    ,
    .cpu_grants   (cpu_grants),
    .dbg_grants   (dbg_grants),
    .stall_cycles (stall_cycles)
`endif
  );

  // ---------------- clock / reset / memory model ----------------
  always #5 clk = ~clk;

  logic [DATA_W-1:0] ram [0:127];
  logic [DATA_W-1:0] pipe [MEM_LAT];
  logic              pre_en = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : '0;
    for (int k = 1; k < MEM_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign mem_rdata = pipe[MEM_LAT-1];

  initial begin
    #500000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
    dbg_if.req = 1'b0; dbg_if.we = 1'b0; dbg_if.addr = '0; dbg_if.wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    cyc();
    pre_en   = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drop_all();
    rst = 1'b1;
    cyc();
    @(negedge clk);
    checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      failures++; $display("FAIL reset_mem_bus got=%0h exp=0", {mem_en, mem_we, mem_addr, mem_wdata}); end
    checks++; if ({cpu_if.ack, dbg_if.ack} !== 2'b00) begin
      failures++; $display("FAIL reset_acks got=%b exp=00", {cpu_if.ack, dbg_if.ack}); end
    checks++; if ({cpu_if.rdata, dbg_if.rdata} !== '0) begin
      failures++; $display("FAIL reset_rdata got=%0h exp=0", {cpu_if.rdata, dbg_if.rdata}); end
    checks++; if ({busy, cpu_stall} !== 2'b00) begin
      failures++; $display("FAIL reset_busy_stall got=%b exp=00", {busy, cpu_stall}); end
    checks++; if (o_state !== IDLE) begin
      failures++; $display("FAIL reset_state got=%0d exp=%0d", o_state, IDLE); end
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_cpu_read();
    int en_cyc = -1, ack_cyc = -1, en_cnt = 0, stall_err = 0, busy_err = 0;
    logic [ADDR_W-1:0] en_addr = '0;
    logic              en_we = 1'b1;
    logic [DATA_W-1:0] ack_data = '0;
    preload(7'h10, 32'hDEADBEEF);
    cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 7'h10;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_en) begin
        en_cnt++;
        if (en_cyc < 0) begin en_cyc = c; en_addr = mem_addr; en_we = mem_we; end
      end
      if (c <= 4 && cpu_stall !== (c < 4)) stall_err++;
      if (c <= 4 && busy !== (c >= 1)) busy_err++;
      if (cpu_if.ack && ack_cyc < 0) begin ack_cyc = c; ack_data = cpu_if.rdata; end
      cyc();
      if (ack_cyc >= 0) cpu_if.req = 1'b0;
    end
    checks++; if (en_cyc !== 1) begin failures++; $display("FAIL cpu_read_en_cycle got=%0d exp=1", en_cyc); end
    checks++; if ({en_addr, en_we} !== {7'h10, 1'b0}) begin
      failures++; $display("FAIL cpu_read_en_addr got=%0h/%b exp=10/0", en_addr, en_we); end
    checks++; if (en_cnt !== 1) begin failures++; $display("FAIL cpu_read_en_count got=%0d exp=1", en_cnt); end
    checks++; if (ack_cyc !== 4) begin failures++; $display("FAIL cpu_read_ack_cycle got=%0d exp=4", ack_cyc); end
    checks++; if (ack_data !== 32'hDEADBEEF) begin
      failures++; $display("FAIL cpu_read_data got=%0h exp=deadbeef", ack_data); end
    checks++; if (stall_err !== 0) begin failures++; $display("FAIL cpu_read_stall got=%0d_bad exp=0", stall_err); end
    checks++; if (busy_err !== 0) begin failures++; $display("FAIL cpu_read_busy got=%0d_bad exp=0", busy_err); end
    checks++; if (cpu_if.rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL cpu_read_hold got=%0h exp=deadbeef", cpu_if.rdata); end
  endtask

  task automatic test_tie();
    int ne = 0, cpu_ack_c = -1, dbg_ack_c = -1, dbl = 0;
    int en_c [2] = '{-1, -1};
    logic [ADDR_W-1:0] en_a [2] = '{'0, '0};
    logic              en_w [2] = '{1'b0, 1'b0};
    logic [DATA_W-1:0] en_d [2] = '{'0, '0};
    logic [DATA_W-1:0] cpu_d = '0;
    do_reset();
    preload(7'h01, 32'hA5A50001);
    preload(7'h02, 32'h0);
    cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 7'h01;
    dbg_if.req = 1'b1; dbg_if.we = 1'b1; dbg_if.addr = 7'h02; dbg_if.wdata = 32'h1234;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_en && ne < 2) begin en_c[ne] = c; en_a[ne] = mem_addr; en_w[ne] = mem_we; en_d[ne] = mem_wdata; ne++; end
      if (cpu_if.ack && dbg_if.ack) dbl++;
      if (cpu_if.ack && cpu_ack_c < 0) begin cpu_ack_c = c; cpu_d = cpu_if.rdata; end
      if (dbg_if.ack && dbg_ack_c < 0) dbg_ack_c = c;
      cyc();
      if (cpu_ack_c >= 0) cpu_if.req = 1'b0;
      if (dbg_ack_c >= 0) dbg_if.req = 1'b0;
    end
    drop_all();
    checks++; if ({en_c[0], en_a[0], en_w[0]} !== {32'sd1, 7'h01, 1'b0}) begin
      failures++; $display("FAIL tie_first_grant got=c%0d/a%0h/w%b exp=c1/a1/w0", en_c[0], en_a[0], en_w[0]); end
    checks++; if (cpu_ack_c !== 4) begin failures++; $display("FAIL tie_cpu_ack got=%0d exp=4", cpu_ack_c); end
    checks++; if (cpu_d !== 32'hA5A50001) begin failures++; $display("FAIL tie_cpu_data got=%0h exp=a5a50001", cpu_d); end
    checks++; if ({en_c[1], en_a[1], en_w[1], en_d[1]} !== {32'sd6, 7'h02, 1'b1, 32'h1234}) begin
      failures++; $display("FAIL tie_dbg_issue got=c%0d/a%0h/w%b/d%0h exp=c6/a2/w1/d1234", en_c[1], en_a[1], en_w[1], en_d[1]); end
    checks++; if (dbg_ack_c !== 9) begin failures++; $display("FAIL tie_dbg_ack got=%0d exp=9", dbg_ack_c); end
    checks++; if (dbg_if.rdata !== 32'h0) begin failures++; $display("FAIL tie_dbg_rdata_kept got=%0h exp=0", dbg_if.rdata); end
    checks++; if (ram[2] !== 32'h1234) begin failures++; $display("FAIL tie_ram_written got=%0h exp=1234", ram[2]); end
    checks++; if (dbl !== 0) begin failures++; $display("FAIL tie_double_ack got=%0d exp=0", dbl); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] exp_q [$];
    owner_t            own_q [$];
    int acks = 0, dbl = 0;
    do_reset();
    preload(7'h20, 32'hC0C00020);
    preload(7'h30, 32'hD0D00030);
    for (int i = 0; i < 3; i++) begin
      own_q.push_back(OWN_CPU); exp_q.push_back(32'hC0C00020);
      own_q.push_back(OWN_DBG); exp_q.push_back(32'hD0D00030);
    end
    cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 7'h20;
    dbg_if.req = 1'b1; dbg_if.we = 1'b0; dbg_if.addr = 7'h30;
    for (int c = 0; c < 60 && acks < 6; c++) begin
      @(negedge clk);
      if (cpu_if.ack && dbg_if.ack) dbl++;
      if ((cpu_if.ack || dbg_if.ack) && own_q.size() > 0) begin
        owner_t            got_own;
        logic [DATA_W-1:0] got_d;
        owner_t            e_own;
        logic [DATA_W-1:0] e_d;
        got_own = cpu_if.ack ? OWN_CPU : OWN_DBG;
        got_d   = cpu_if.ack ? cpu_if.rdata : dbg_if.rdata;
        e_own   = own_q.pop_front();
        e_d     = exp_q.pop_front();
        checks++; if (got_own !== e_own) begin
          failures++; $display("FAIL b2b_owner[%0d] got=%0d exp=%0d", acks, got_own, e_own); end
        checks++; if (got_d !== e_d) begin
          failures++; $display("FAIL b2b_data[%0d] got=%0h exp=%0h", acks, got_d, e_d); end
        checks++; if (c !== 4 + 5 * acks) begin
          failures++; $display("FAIL b2b_ack_cycle[%0d] got=%0d exp=%0d", acks, c, 4 + 5 * acks); end
        acks++;
      end
      cyc();
      if (acks == 6) drop_all();
    end
    drop_all();
    checks++; if (acks !== 6) begin failures++; $display("FAIL b2b_ack_count got=%0d exp=6", acks); end
    checks++; if (dbl !== 0) begin failures++; $display("FAIL b2b_double_ack got=%0d exp=0", dbl); end
  endtask

  task automatic test_lock();
    int en_err = 0, stall_err = 0, en_cyc = -1, ack_cyc = -1;
    cyc();
    dbg_lock = 1'b1;
    cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 7'h10;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_en) en_err++;
      if (cpu_stall !== 1'b1) stall_err++;
      cyc();
    end
    dbg_lock = 1'b0;
    for (int c = 20; c < 32; c++) begin
      @(negedge clk);
      if (mem_en && en_cyc < 0) en_cyc = c;
      if (cpu_if.ack && ack_cyc < 0) ack_cyc = c;
      cyc();
      if (ack_cyc >= 0) cpu_if.req = 1'b0;
    end
    checks++; if (en_err !== 0) begin failures++; $display("FAIL lock_no_issue got=%0d_issues exp=0", en_err); end
    checks++; if (stall_err !== 0) begin failures++; $display("FAIL lock_stall got=%0d_bad exp=0", stall_err); end
    checks++; if (en_cyc !== 21) begin failures++; $display("FAIL lock_release_issue got=%0d exp=21", en_cyc); end
    checks++; if (ack_cyc !== 24) begin failures++; $display("FAIL lock_release_ack got=%0d exp=24", ack_cyc); end
    checks++; if (cpu_if.rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL lock_read_data got=%0h exp=deadbeef", cpu_if.rdata); end
  endtask

  task automatic test_reset_mid();
    int stale_ack = 0, first_c = -1, cpu_done = -1, dbg_done = -1;
    logic [ADDR_W-1:0] first_a = '0;
    logic              first_w = 1'b1;
    cyc();
    cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 7'h20;
    cyc();
    cyc();
    #2;
    checks++; if (o_state !== WAIT) begin failures++; $display("FAIL midrst_in_wait got=%0d exp=%0d", o_state, WAIT); end
    rst = 1'b1;
    #1;
    checks++; if ({mem_en, mem_we, mem_addr, mem_wdata, cpu_if.ack, dbg_if.ack, busy} !== '0) begin
      failures++; $display("FAIL midrst_outputs got=%0h exp=0", {mem_en, mem_we, mem_addr, mem_wdata, cpu_if.ack, dbg_if.ack, busy}); end
    checks++; if (cpu_if.rdata !== 32'h0) begin failures++; $display("FAIL midrst_rdata got=%0h exp=0", cpu_if.rdata); end
    cpu_if.req = 1'b0;
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (cpu_if.ack || mem_en) stale_ack++;
      cyc();
    end
    checks++; if (stale_ack !== 0) begin failures++; $display("FAIL midrst_abandoned got=%0d_events exp=0", stale_ack); end
    cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 7'h01;
    dbg_if.req = 1'b1; dbg_if.we = 1'b0; dbg_if.addr = 7'h02;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_en && first_c < 0) begin first_c = c; first_a = mem_addr; first_w = mem_we; end
      if (cpu_if.ack && cpu_done < 0) cpu_done = c;
      if (dbg_if.ack && dbg_done < 0) dbg_done = c;
      cyc();
      if (cpu_done >= 0) cpu_if.req = 1'b0;
      if (dbg_done >= 0) dbg_if.req = 1'b0;
    end
    drop_all();
    checks++; if ({first_c, first_a, first_w} !== {32'sd1, 7'h01, 1'b0}) begin
      failures++; $display("FAIL midrst_tie_grant got=c%0d/a%0h/w%b exp=c1/a1/w0", first_c, first_a, first_w); end
    checks++; if ({cpu_done, dbg_done} !== {32'sd4, 32'sd9}) begin
      failures++; $display("FAIL midrst_tie_acks got=%0d/%0d exp=4/9", cpu_done, dbg_done); end
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int n = 0; n < 3; n++) begin
      int lat = -1;
      cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 7'h10;
      for (int c = 0; c < 12 && lat < 0; c++) begin
        @(negedge clk);
        if (cpu_if.ack) lat = c;
        cyc();
      end
      cpu_if.req = 1'b0;
      cyc();
      checks++; if (lat !== MEM_LAT + 2) begin
        failures++; $display("FAIL stats_latency[%0d] got=%0d exp=%0d", n, lat, MEM_LAT + 2); end
    end
    checks++; if ({cpu_grants, dbg_grants} !== {16'd3, 16'd0}) begin
      failures++; $display("FAIL stats_grants got=%0d/%0d exp=3/0", cpu_grants, dbg_grants); end
    checks++; if (stall_cycles !== 16'(3 * (MEM_LAT + 2))) begin
      failures++; $display("FAIL stats_stall got=%0d exp=%0d", stall_cycles, 3 * (MEM_LAT + 2)); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    drop_all();
    test_reset();
    test_cpu_read();
    test_tie();
    test_back_to_back();
    test_lock();
    test_reset_mid();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
